// File: rtl/async_fifo_pkg.sv
// Shared pointer helpers for the async FIFO read and write sides.
// Both sides must agree on the Gray-to-RAM-address mapping.
package async_fifo_pkg;

  localparam int PTR_W_DEF = 5;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // Callers zero-extend narrower pointers.
  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b = g;
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] gray_to_addr(
    input logic [31:0] g,
    input int          w
  );
    logic [31:0] a;
    a = g & ((32'd1 << (w - 2)) - 32'd1);
    a[w-2] = g[w-1] ^ g[w-2];
    return a;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Parameterized XOR-prefix Gray-to-binary converter.
// Bit i of the result is the XOR of Gray bits W-1 down to i.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end

endmodule

// File: rtl/wptr_handler.sv
// Write-side pointer, address and flag logic of the async FIFO.
// Flags compare against the synchronized, hence pessimistic, read pointer.
module wptr_handler
  import async_fifo_pkg::*;
#(
  parameter int n         = PTR_W_DEF,
  parameter int AF_THRESH = 12
) (
  input  logic         clk,
  input  logic         wresetn,
  input  logic         winc,
  input  logic [n-1:0] rq2_rptr,
  input  logic         clr_ovf,
  output logic         wen,
  output logic [n-2:0] waddr,
  output logic [n-1:0] wptr,
  output logic         full,
  output logic         almost_full,
  output logic [n-1:0] wlevel,
  output logic         overflow
);

  logic [n-1:0] r_wbin;
  logic [n-1:0] r_wptr;
  logic [n-2:0] r_waddr;
  logic [n-1:0] r_wlevel;
  logic         r_full;
  logic         r_af;
  logic         r_ovf;

  logic [n-1:0] w_wbin_next;
  logic [n-1:0] w_wgray_next;
  logic [n-1:0] w_rbin;
  logic [n-1:0] w_level;
  logic [n-1:0] w_full_cmp;
  logic [31:0]  w_g32;
  logic [31:0]  w_a32;

  assign wen          = winc & ~r_full;
  assign w_wbin_next  = r_wbin + {{(n-1){1'b0}}, wen};
  assign w_g32        = bin2gray(32'(w_wbin_next));
  assign w_wgray_next = w_g32[n-1:0];
  assign w_a32        = gray_to_addr(w_g32, n);

  gray2bin_conv #(
    .W (n)
  ) u_rconv (
    .i_gray (rq2_rptr),
    .o_bin  (w_rbin)
  );

  assign w_level    = w_wbin_next - w_rbin;
  assign w_full_cmp = {~rq2_rptr[n-1:n-2], rq2_rptr[n-3:0]};

  always_ff @(posedge clk) begin
    if (!wresetn) begin
      r_wbin   <= '0;
      r_wptr   <= '0;
      r_waddr  <= '0;
      r_wlevel <= '0;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_wbin   <= w_wbin_next;
      r_wptr   <= w_wgray_next;
      r_waddr  <= w_a32[n-2:0];
      r_wlevel <= w_level;
      r_full   <= (w_wgray_next == w_full_cmp);
      r_af     <= (32'(w_level) >= 32'(AF_THRESH));
      // set wins over a coincident clear
      if (winc && r_full)
        r_ovf <= 1'b1;
      else if (clr_ovf)
        r_ovf <= 1'b0;
    end
  end

  assign waddr       = r_waddr;
  assign wptr        = r_wptr;
  assign full        = r_full;
  assign almost_full = r_af;
  assign wlevel      = r_wlevel;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_wptr_handler.sv
// Directed bench for wptr_handler at default parameters.
// Inputs change 1ns after posedge; registered outputs checked there too.
module tb_wptr_handler;

  logic       clk = 1'b0;
  logic       wresetn;
  logic       winc;
  logic [4:0] rq2_rptr;
  logic       clr_ovf;
  logic       wen;
  logic [3:0] waddr;
  logic [4:0] wptr;
  logic       full;
  logic       almost_full;
  logic [4:0] wlevel;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wptr_handler #(
    .n         (5),
    .AF_THRESH (12)
  ) dut (
    .clk         (clk),
    .wresetn     (wresetn),
    .winc        (winc),
    .rq2_rptr    (rq2_rptr),
    .clr_ovf     (clr_ovf),
    .wen         (wen),
    .waddr       (waddr),
    .wptr        (wptr),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow)
  );

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic logic [3:0] addr_of(input int b);
    logic [4:0] g;
    g = gray(b);
    return {g[4] ^ g[3], g[2:0]};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wb;
    logic [15:0] seen;
    wresetn  = 1'b0;
    winc     = 1'b1;
    rq2_rptr = 5'd0;
    clr_ovf  = 1'b0;
    tick(); tick(); tick();
    chk("rst_wptr", 32'(wptr), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_wlevel", 32'(wlevel), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_wen", 32'(wen), 1);

    wresetn = 1'b1;
    seen = '0;
    for (int i = 1; i <= 16; i++) begin
      chk("fill_addr", 32'(waddr), 32'(addr_of(i - 1)));
      seen[waddr] = 1'b1;
      tick();
      chk("fill_lvl", 32'(wlevel), 32'(i));
      chk("fill_af", 32'(almost_full), 32'(i >= 12));
      chk("fill_full", 32'(full), 32'(i == 16));
    end
    chk("fill_wptr", 32'(wptr), 32'h18);
    chk("fill_distinct", 32'(seen), 32'hFFFF);

    #1;
    chk("ovf_wen", 32'(wen), 0);
    tick();
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_wptr", 32'(wptr), 32'h18);
    tick();
    chk("ovf_hold", 32'(overflow), 1);
    chk("ovf_lvl", 32'(wlevel), 16);
    winc = 1'b0;
    clr_ovf = 1'b1;
    tick();
    chk("ovf_clr", 32'(overflow), 0);
    clr_ovf = 1'b0;

    rq2_rptr = 5'b00110;
    tick();
    chk("drain_full", 32'(full), 0);
    chk("drain_lvl12", 32'(wlevel), 12);
    chk("drain_af1", 32'(almost_full), 1);
    rq2_rptr = 5'b00111;
    tick();
    chk("drain_lvl11", 32'(wlevel), 11);
    chk("drain_af0", 32'(almost_full), 0);

    wb = 16;
    rq2_rptr = gray(14);
    tick();
    chk("wrap_pre", 32'(wlevel), 2);
    winc = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rq2_rptr = gray(wb - 1);
      wb = (wb + 1) % 32;
      tick();
      chk("wrap_lvl", 32'(wlevel), 2);
      chk("wrap_full", 32'(full), 0);
      chk("wrap_wptr", 32'(wptr), 32'(gray(wb)));
      chk("wrap_addr", 32'(waddr), 32'(addr_of(wb)));
    end

    winc = 1'b0;
    rq2_rptr = gray(wb - 9);
    tick();
    chk("mid_lvl9", 32'(wlevel), 9);
    wresetn = 1'b0;
    winc = 1'b1;
    tick();
    chk("mid_wptr", 32'(wptr), 0);
    chk("mid_waddr", 32'(waddr), 0);
    chk("mid_lvl", 32'(wlevel), 0);
    chk("mid_full", 32'(full), 0);
    chk("mid_af", 32'(almost_full), 0);
    chk("mid_ovf", 32'(overflow), 0);

    wresetn = 1'b1;
    rq2_rptr = 5'd0;
    for (int i = 0; i < 15; i++) tick();
    chk("sim_pre15", 32'(wlevel), 15);
    chk("sim_pre_af", 32'(almost_full), 1);
    rq2_rptr = 5'b00001;
    tick();
    chk("sim_lvl", 32'(wlevel), 15);
    chk("sim_full", 32'(full), 0);
    winc = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
